// File: rtl/pixel_threshold.sv
// pixel_threshold: per-pixel threshold stage for the grayscale stream.
// Four runtime modes (BINARY, BINARY_INV, TRUNC, TOZERO), with threshold and
// mode shadowed per frame and taken at the (0,0) pixel. Row/col tracking,
// end-of-frame flag and a fixed two-cycle latency.
// Optional per-frame foreground count: define PIXEL_THRESHOLD_STATS_EN.
module pixel_threshold #(
    parameter int IMAGE_WIDTH    = 320,
    parameter int IMAGE_HEIGHT   = 240,
    parameter int DATA_W         = 8,
    parameter int THRESH_DEFAULT = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sof,
    input  logic [DATA_W-1:0] cfg_thresh,
    input  logic [1:0]        cfg_mode,
    input  logic              gray_valid,
    input  logic [DATA_W-1:0] gray,
    output logic              bin_valid,
    output logic [DATA_W-1:0] bin_out,
    output logic [31:0]       pix_row,
    output logic [31:0]       pix_col,
    output logic              eof_out,
    output logic              stat_valid,
    output logic [31:0]       stat_fg_count
);

    localparam logic [DATA_W-1:0] MAX_VAL  = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] T_RST    = DATA_W'(THRESH_DEFAULT);
    localparam logic [31:0]       LAST_COL = 32'(IMAGE_WIDTH - 1);
    localparam logic [31:0]       LAST_ROW = 32'(IMAGE_HEIGHT - 1);

    localparam logic [1:0] M_BINARY     = 2'd0;
    localparam logic [1:0] M_BINARY_INV = 2'd1;
    localparam logic [1:0] M_TRUNC      = 2'd2;

    // Position counters hold the coordinate the next accepted pixel will get.
    logic [31:0]       row_q, row_d, col_q, col_d;
    logic [DATA_W-1:0] t_act_q, t_act_d;
    logic [1:0]        mode_act_q, mode_act_d;

    // Stage 1 registers
    logic              s1_vld_q, s1_vld_d;
    logic [DATA_W-1:0] s1_pix_q, s1_pix_d, s1_t_q, s1_t_d;
    logic [1:0]        s1_mode_q, s1_mode_d;
    logic [31:0]       s1_row_q, s1_row_d, s1_col_q, s1_col_d;

    // Stage 2 (output) registers
    logic              bin_valid_q, bin_valid_d;
    logic [DATA_W-1:0] bin_out_q, bin_out_d;
    logic [31:0]       pix_row_q, pix_row_d, pix_col_q, pix_col_d;
    logic              eof_q, eof_d;

    logic [31:0]       cur_row, cur_col;
    logic              cur_first;
    logic              s1_hit, s1_last;

    // Stage 0: assign coordinates, advance counters, latch frame config at (0,0)
    always_comb begin
        cur_row    = sof ? 32'd0 : row_q;
        cur_col    = sof ? 32'd0 : col_q;
        cur_first  = (cur_row == 32'd0) && (cur_col == 32'd0);
        row_d      = row_q;
        col_d      = col_q;
        t_act_d    = t_act_q;
        mode_act_d = mode_act_q;
        s1_vld_d   = gray_valid;
        s1_pix_d   = s1_pix_q;
        s1_t_d     = s1_t_q;
        s1_mode_d  = s1_mode_q;
        s1_row_d   = s1_row_q;
        s1_col_d   = s1_col_q;
        if (gray_valid) begin
            // The (0,0) pixel already uses the freshly requested config.
            if (cur_first) begin
                t_act_d    = cfg_thresh;
                mode_act_d = cfg_mode;
            end
            s1_pix_d  = gray;
            s1_t_d    = cur_first ? cfg_thresh : t_act_q;
            s1_mode_d = cur_first ? cfg_mode : mode_act_q;
            s1_row_d  = cur_row;
            s1_col_d  = cur_col;
            if (cur_col == LAST_COL) begin
                col_d = 32'd0;
                row_d = (cur_row == LAST_ROW) ? 32'd0 : cur_row + 32'd1;
            end else begin
                col_d = cur_col + 32'd1;
                row_d = cur_row;
            end
        end else if (sof) begin
            row_d = 32'd0;
            col_d = 32'd0;
        end
    end

    // Stage 2: apply the threshold mode; outputs hold when no pixel arrives
    always_comb begin
        s1_hit      = (s1_pix_q >= s1_t_q);
        s1_last     = (s1_row_q == LAST_ROW) && (s1_col_q == LAST_COL);
        bin_valid_d = s1_vld_q;
        eof_d       = s1_vld_q && s1_last;
        bin_out_d   = bin_out_q;
        pix_row_d   = pix_row_q;
        pix_col_d   = pix_col_q;
        if (s1_vld_q) begin
            pix_row_d = s1_row_q;
            pix_col_d = s1_col_q;
            case (s1_mode_q)
                M_BINARY:     bin_out_d = s1_hit ? MAX_VAL : '0;
                M_BINARY_INV: bin_out_d = s1_hit ? '0 : MAX_VAL;
                M_TRUNC:      bin_out_d = s1_hit ? s1_t_q : s1_pix_q;
                default:      bin_out_d = s1_hit ? s1_pix_q : '0;
            endcase
        end
    end

    // Pipeline and counter state; reset drops anything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q       <= '0;
            col_q       <= '0;
            t_act_q     <= T_RST;
            mode_act_q  <= '0;
            s1_vld_q    <= 1'b0;
            s1_pix_q    <= '0;
            s1_t_q      <= '0;
            s1_mode_q   <= '0;
            s1_row_q    <= '0;
            s1_col_q    <= '0;
            bin_valid_q <= 1'b0;
            bin_out_q   <= '0;
            pix_row_q   <= '0;
            pix_col_q   <= '0;
            eof_q       <= 1'b0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            t_act_q     <= t_act_d;
            mode_act_q  <= mode_act_d;
            s1_vld_q    <= s1_vld_d;
            s1_pix_q    <= s1_pix_d;
            s1_t_q      <= s1_t_d;
            s1_mode_q   <= s1_mode_d;
            s1_row_q    <= s1_row_d;
            s1_col_q    <= s1_col_d;
            bin_valid_q <= bin_valid_d;
            bin_out_q   <= bin_out_d;
            pix_row_q   <= pix_row_d;
            pix_col_q   <= pix_col_d;
            eof_q       <= eof_d;
        end
    end

    assign bin_valid = bin_valid_q;
    assign bin_out   = bin_out_q;
    assign pix_row   = pix_row_q;
    assign pix_col   = pix_col_q;
    assign eof_out   = eof_q;

`ifdef PIXEL_THRESHOLD_STATS_EN
    logic [31:0] acc_q, acc_d, acc_base;
    logic [31:0] stat_cnt_q, stat_cnt_d;
    logic        stat_vld_q, stat_vld_d;

    // Hit accumulator restarts on each (0,0) pixel, so a sof-abandoned frame
    // is discarded without ever being reported.
    always_comb begin
        acc_base   = (s1_row_q == 32'd0 && s1_col_q == 32'd0) ? 32'd0 : acc_q;
        acc_d      = acc_q;
        stat_cnt_d = stat_cnt_q;
        stat_vld_d = 1'b0;
        if (s1_vld_q) begin
            acc_d = acc_base + 32'(s1_hit);
            if (s1_last) begin
                stat_vld_d = 1'b1;
                stat_cnt_d = acc_base + 32'(s1_hit);
            end
        end
    end

    // Statistic registers, aligned with eof_out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            stat_cnt_q <= '0;
            stat_vld_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            stat_cnt_q <= stat_cnt_d;
            stat_vld_q <= stat_vld_d;
        end
    end

    assign stat_valid    = stat_vld_q;
    assign stat_fg_count = stat_cnt_q;
`else
    assign stat_valid    = 1'b0;
    assign stat_fg_count = 32'd0;
`endif

endmodule
